// File: rtl/div_ctrl_pkg.sv
// Shared types for the ratio-change controller: FSM state encoding and the
// default ratio/counter width.
package div_ctrl_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_core.sv
// Programmable clock divider: counts 0..cur_n, toggles fout on terminal count,
// and accepts a new ratio through a synchronous load that restarts the low phase.
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int          W     = DEF_W,
    parameter int unsigned DEF_N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_n,
    output logic [W-1:0] cur_n,
    output logic         fout,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == cur_n);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            fout  <= 1'b0;
            cur_n <= W'(DEF_N);
        end else if (ld) begin
            // Load only happens at the end of a high phase, so forcing fout low
            // here is the regular falling edge, never a runt.
            cnt   <= '0;
            fout  <= 1'b0;
            cur_n <= ld_n;
        end else if (tc) begin
            cnt  <= '0;
            fout <= ~fout;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Ratio-change controller: round-robin arbitration between two requesters and
// a glitch-free hand-over of the new ratio to the divider core.
module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int          W     = DEF_W,
    parameter int unsigned DEF_N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] ratio0,
    input  logic [W-1:0] ratio1,
    output logic [1:0]   gnt,
    output logic         err,
    output logic         done,
    output logic         busy,
    output logic [W-1:0] cur_n,
    output logic         fout,
    output logic         tc
);

    state_t       state;
    logic [W-1:0] pend_n;
    logic         last;       // index of the requester granted most recently
    logic         win;
    logic [1:0]   win_oh;
    logic [W-1:0] win_ratio;
    logic         ld;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        win = req[1];
        if (req == 2'b11)
            win = ~last;
        win_oh    = win ? 2'b10 : 2'b01;
        win_ratio = win ? ratio1 : ratio0;
    end

    // Swap ratios only at the end of a high phase so neither half-period is cut short.
    assign ld   = (state == WAIT) && tc && fout;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend_n <= '0;
            gnt    <= 2'b00;
            err    <= 1'b0;
            done   <= 1'b0;
            last   <= 1'b1;
        end else begin
            gnt  <= 2'b00;
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A held req is ignored during its own gnt cycle.
                    if (req != 2'b00 && gnt == 2'b00) begin
                        gnt    <= win_oh;
                        last   <= win;
                        pend_n <= win_ratio;
                        if (win_ratio == '0)
                            err <= 1'b1;
                        else
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ld) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    div_core #(
        .W     (W),
        .DEF_N (DEF_N)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .ld_n  (pend_n),
        .cur_n (cur_n),
        .fout  (fout),
        .tc    (tc)
    );

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: directed scenarios plus random
// requests, compared every cycle against a phase-based reference model.
module tb_div_ratio_ctrl;

    localparam int W     = 8;
    localparam int DEF_N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] ratio0, ratio1;
    logic [1:0]   gnt;
    logic         err, done, busy, fout, tc;
    logic [W-1:0] cur_n;

    div_ratio_ctrl #(.W(W), .DEF_N(DEF_N)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ratio0 (ratio0),
        .ratio1 (ratio1),
        .gnt    (gnt),
        .err    (err),
        .done   (done),
        .busy   (busy),
        .cur_n  (cur_n),
        .fout   (fout),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the divider is a position m_t within a period of
    // 2*(m_n+1) cycles; fout is high in the second half.
    int       m_n, m_t, m_pend, m_last;
    bit       m_wait, m_done, m_err;
    bit [1:0] m_gnt;

    int  cyc;
    int  gnt_cyc, gnt_old_n;
    bit  autodrop;
    bit  rand_mode;
    int  gnt0_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_n = DEF_N; m_t = 0; m_pend = 0; m_last = 1;
        m_wait = 0; m_done = 0; m_err = 0; m_gnt = 2'b00;
        gnt_cyc = 0; gnt_old_n = DEF_N;
    endtask

    task automatic compare_all();
        check("fout",  32'(fout),  32'(m_t > m_n));
        check("tc",    32'(tc),    32'((m_t == m_n) || (m_t == 2*m_n + 1)));
        check("cur_n", 32'(cur_n), 32'(m_n));
        check("busy",  32'(busy),  32'(m_wait || m_done));
        check("gnt",   32'(gnt),   32'(m_gnt));
        check("err",   32'(err),   32'(m_err));
        check("done",  32'(done),  32'(m_done));
        if (gnt != 2'b00 && !err) begin
            gnt_cyc   = cyc;
            gnt_old_n = int'(cur_n);
        end
        if (done)
            check("latency_ok", 32'((cyc - gnt_cyc) <= 2*(gnt_old_n + 1) + 1), 32'd1);
        if (gnt[0])
            gnt0_pulses++;
    endtask

    // Advance one clock: predict next model state from current inputs, clock,
    // then compare at the falling edge.
    task automatic cycle();
        int nn, nt, np, nl, w;
        bit nw, nd, ne, ld;
        bit [1:0] ng;
        nn = m_n; np = m_pend; nl = m_last;
        ld = m_wait && (m_t == 2*m_n + 1);
        nt = (m_t == 2*m_n + 1) ? 0 : m_t + 1;
        if (ld) nn = m_pend;
        nw = m_wait && !ld;
        nd = ld;
        ne = 0;
        ng = 2'b00;
        if (!m_wait && !m_done && m_gnt == 2'b00 && req != 2'b00) begin
            if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
            else              w = req[1] ? 1 : 0;
            ng = (w == 1) ? 2'b10 : 2'b01;
            nl = w;
            np = (w == 1) ? int'(ratio1) : int'(ratio0);
            if (np == 0) ne = 1;
            else         nw = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        m_n = nn; m_t = nt; m_pend = np; m_last = nl;
        m_wait = nw; m_done = nd; m_err = ne; m_gnt = ng;
        compare_all();
        if (autodrop)
            req = req & ~m_gnt;
        if (rand_mode) begin
            if (!req[0] && $urandom_range(0, 9) == 0) begin
                req[0] = 1'b1; ratio0 = W'($urandom_range(0, 6));
            end
            if (!req[1] && $urandom_range(0, 9) == 0) begin
                req[1] = 1'b1; ratio1 = W'($urandom_range(0, 6));
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Async reset asserted at a falling edge, held over one rising edge.
    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; ratio0 = '0; ratio1 = '0;
        cyc = 0; autodrop = 1; rand_mode = 0; gnt0_pulses = 0;
        @(negedge clk);

        // Reset state and default period of 6.
        do_reset();
        run(14);

        // Single requester, ratio 4.
        req = 2'b01; ratio0 = 8'd4;
        run(45);
        check("cur_n_after_4", 32'(cur_n), 32'd4);

        // Simultaneous requests right after reset: 0 first, then 1.
        do_reset();
        req = 2'b11; ratio0 = 8'd3; ratio1 = 8'd5;
        run(40);
        check("cur_n_after_rr", 32'(cur_n), 32'd5);

        // Zero ratio rejected.
        do_reset();
        req = 2'b10; ratio1 = 8'd0;
        run(8);
        check("cur_n_after_err", 32'(cur_n), 32'(DEF_N));

        // Reset while WAIT holds ratio 7.
        do_reset();
        req = 2'b01; ratio0 = 8'd7;
        run(3);
        check("busy_in_wait", 32'(busy), 32'd1);
        do_reset();
        run(14);

        // Request held through its own gnt cycle: exactly one gnt.
        autodrop = 0;
        gnt0_pulses = 0;
        req = 2'b01; ratio0 = 8'd0;
        for (int i = 0; i < 10 && m_gnt == 2'b00; i++) cycle();
        check("gnt_seen", 32'(m_gnt), 32'b01);
        cycle();
        req = 2'b00;
        run(4);
        check("single_gnt", 32'(gnt0_pulses), 32'd1);
        autodrop = 1;

        // Randomized traffic, including zero ratios and requests while busy.
        do_reset();
        rand_mode = 1;
        run(3000);
        rand_mode = 0;
        req = 2'b00;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
